axis_width_downsizer: RTL and testbench
=======================================

AXIS_WIDTH_DOWNSIZER -- requirements
Module: axis_width_downsizer

Interface
REQ-001 SHALL have parameter S_AXIS_TDATA_WIDTH, default 64: slave (input) data width in bits.
REQ-002 SHALL have parameter M_AXIS_TDATA_WIDTH, default 32: master (output) data width in bits.
- Legal configurations: S_AXIS_TDATA_WIDTH = RATIO*M_AXIS_TDATA_WIDTH, with RATIO a power of two, 2..8.
REQ-003 SHALL have port aclk  input  1  sole clock; all logic on the rising edge.
REQ-004 SHALL have port aresetn  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port s_axis_tdata  input  S_AXIS_TDATA_WIDTH  wide input beat.
REQ-006 SHALL have port s_axis_tvalid  input  1  input beat valid.
REQ-007 SHALL have port s_axis_tlast  input  1  input beat ends a packet.
REQ-008 SHALL have port s_axis_tready  output  1  input beat accepted when high with tvalid.
REQ-009 SHALL have port m_axis_tdata  output  M_AXIS_TDATA_WIDTH  narrow output word.
REQ-010 SHALL have port m_axis_tvalid  output  1  output word valid.
REQ-011 SHALL have port m_axis_tlast  output  1  output word ends a packet.
REQ-012 SHALL have port m_axis_tready  input  1  downstream accepts the word.

Function
REQ-013 SHALL split each accepted input beat into RATIO output words, least-significant slice first: word k = s_axis_tdata[(k+1)*M-1 : k*M].
REQ-014 SHALL hold the accepted beat in a holding register, plus a slice index idx of width log2(RATIO), plus a full flag.
REQ-015 SHALL define two states:
- EMPTY: full=0.
- ACTIVE: full=1; m_axis_tvalid=1; m_axis_tdata = slice idx of the holding register.
REQ-016 SHALL transition EMPTY->ACTIVE on a slave handshake; m_axis_tvalid rises the cycle after acceptance (latency 1 cycle).
REQ-017 In ACTIVE, each master handshake (m_axis_tvalid & m_axis_tready) SHALL increment idx.
- Wrap-around: the handshake with idx=RATIO-1 resets idx to 0 and completes the beat.
REQ-018 SHALL drive s_axis_tready = !full | (m_axis_tready & idx==RATIO-1), combinationally.
REQ-019 Simultaneous completion of the last word and a slave handshake SHALL load the new beat, set idx=0 and stay ACTIVE: no bubble, sustained throughput of one output word per cycle.
REQ-020 Completion of the last word without a slave handshake SHALL go to EMPTY.
REQ-021 SHALL drive m_axis_tlast = stored tlast & (idx==RATIO-1); all other words of the beat carry tlast=0.
REQ-022 While m_axis_tvalid=1 and m_axis_tready=0, m_axis_tdata, m_axis_tlast and m_axis_tvalid SHALL hold stable.
- m_axis_tvalid SHALL NOT deassert before a master handshake.
REQ-023 SHALL ignore s_axis_tdata and s_axis_tlast whenever no slave handshake occurs.
- The holding register loads only on a slave handshake.
REQ-024 SHALL contain no combinational path from s_axis_tvalid or s_axis_tdata to any m_axis_* output.

Reset
REQ-025 While aresetn=0, the block SHALL hold: full=0, idx=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, s_axis_tready=0.
REQ-026 s_axis_tready SHALL go high in the first cycle after aresetn deasserts.
REQ-027 Assertion of aresetn mid-beat SHALL immediately and asynchronously clear m_axis_tvalid and discard the remaining slices.
- After release, the block starts in EMPTY with idx=0.

Verification
REQ-028 Back-to-back input, m_axis_tready=1:
- Stimulus: beats 0x00000001_00000000, 0x00000003_00000002, tvalid held high.
- Response: outputs 0x0, 0x1, 0x2, 0x3 on four consecutive cycles starting one cycle after the first acceptance.
- s_axis_tready toggles 0,1 after the first beat is loaded.
REQ-029 Backpressure:
- Stimulus: beat 0xDEADBEEF_CAFEF00D accepted, m_axis_tready=0 for 5 cycles, then 1.
- Response: 0xCAFEF00D held stable 5 cycles, then 0xDEADBEEF on the next cycle; s_axis_tready=0 throughout the stall.
REQ-030 Packet boundary:
- Stimulus: 3-beat packet with tlast on beat 3.
- Response: m_axis_tlast=1 only on output word 6 (upper half of beat 3).
REQ-031 Gappy source:
- Stimulus: tvalid asserted one cycle in four, m_axis_tready=1.
- Response: each beat yields exactly two words; m_axis_tvalid=0 in the gaps; no duplicated or dropped words.
REQ-032 Reset mid-beat:
- Stimulus: aresetn pulled low after the lower word of 0x11111111_22222222 is output, then released.
- Response: 0x11111111 is never emitted; m_axis_tvalid=0 during and after reset until the next input beat.
REQ-033 Counter loopback (regression):
- Stimulus: 32->64 packed counter stream 0,1,2,... through the block.
- Response: the 32-bit output sequence is 0,1,2,... with no gaps over 1024 words.

Source files
------------

// File: rtl/axis_width_downsizer.sv
// AXI4-Stream width downsizer.
//
// Accepts one wide beat on the slave side and emits it as RATIO narrow words on
// the master side, least-significant slice first. A single holding register
// plus a slice index keeps the beat while its words drain; a new beat may be
// loaded in the same cycle the last word is taken, so a continuous source
// yields one output word per cycle with no bubbles.
//
// Parameters:
//   S_AXIS_TDATA_WIDTH  input beat width  (RATIO * M_AXIS_TDATA_WIDTH)
//   M_AXIS_TDATA_WIDTH  output word width (RATIO a power of two, 2..8)
//
// Ports:
//   aclk           clock, rising edge
//   aresetn        asynchronous active-low reset
//   s_axis_tdata   wide input beat
//   s_axis_tvalid  input beat valid
//   s_axis_tlast   input beat ends a packet
//   s_axis_tready  input beat accepted when high with tvalid
//   m_axis_tdata   narrow output word
//   m_axis_tvalid  output word valid
//   m_axis_tlast   output word ends a packet (last slice of a tlast beat)
//   m_axis_tready  downstream accepts the word
module axis_width_downsizer #(
    parameter int unsigned S_AXIS_TDATA_WIDTH = 64,
    parameter int unsigned M_AXIS_TDATA_WIDTH = 32
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic [S_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                          s_axis_tvalid,
    input  logic                          s_axis_tlast,
    output logic                          s_axis_tready,
    output logic [M_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                          m_axis_tvalid,
    output logic                          m_axis_tlast,
    input  logic                          m_axis_tready
);

    localparam int unsigned RATIO = S_AXIS_TDATA_WIDTH / M_AXIS_TDATA_WIDTH;
    localparam int unsigned IDX_W = $clog2(RATIO);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(RATIO - 1);

    typedef enum logic [0:0] {
        StEmpty,
        StActive
    } state_e;

    state_e                        state_q, state_d;
    logic [IDX_W-1:0]              idx_q, idx_d;
    logic [S_AXIS_TDATA_WIDTH-1:0] data_q;
    logic                          last_q;

    logic                          full;
    logic                          idx_at_max;
    logic                          s_hs;
    logic                          m_hs;
    logic [M_AXIS_TDATA_WIDTH-1:0] slices [RATIO];

    for (genvar k = 0; k < RATIO; k++) begin : g_slice
        assign slices[k] = data_q[k*M_AXIS_TDATA_WIDTH +: M_AXIS_TDATA_WIDTH];
    end

    assign full       = (state_q == StActive);
    assign idx_at_max = (idx_q == IDX_MAX);

    // Gated by aresetn so the slave side reports not-ready while held in reset.
    assign s_axis_tready = aresetn & (~full | (m_axis_tready & idx_at_max));

    // Master outputs depend only on registered state: no path from the slave side.
    assign m_axis_tvalid = full;
    assign m_axis_tdata  = slices[idx_q];
    assign m_axis_tlast  = full & last_q & idx_at_max;

    assign s_hs = s_axis_tvalid & s_axis_tready;
    assign m_hs = m_axis_tvalid & m_axis_tready;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            StEmpty: begin
                if (s_hs) begin
                    state_d = StActive;
                    idx_d   = '0;
                end
            end
            StActive: begin
                if (m_hs) begin
                    if (idx_at_max) begin
                        // Beat done: refill in the same cycle if the source offers one.
                        idx_d   = '0;
                        state_d = s_hs ? StActive : StEmpty;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = StEmpty;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= StEmpty;
            idx_q   <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (s_hs) begin
                data_q <= s_axis_tdata;
                last_q <= s_axis_tlast;
            end
        end
    end

endmodule

// File: tb/tb_axis_width_downsizer.sv
// Self-checking bench for axis_width_downsizer (64 -> 32).
// A word-queue reference model tracks every accepted beat as a list of pending
// output words; valid, ready, data and last are all predicted from that list.
module tb_axis_width_downsizer;

    localparam int unsigned SW    = 64;
    localparam int unsigned MW    = 32;
    localparam int unsigned RATIO = SW / MW;

    logic          aclk;
    logic          aresetn;
    logic [SW-1:0] s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tlast;
    logic          s_axis_tready;
    logic [MW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tlast;
    logic          m_axis_tready;

    axis_width_downsizer #(
        .S_AXIS_TDATA_WIDTH(SW),
        .M_AXIS_TDATA_WIDTH(MW)
    ) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast (s_axis_tlast),
        .s_axis_tready(s_axis_tready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tready(m_axis_tready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        logic [MW-1:0] data;
        logic          last;
    } word_t;

    typedef struct {
        logic [MW-1:0] data;
        logic          last;
        int            cyc;
    } log_t;

    int    checks = 0;
    int    errors = 0;
    int    cyc    = 0;
    bit    s_fire = 0;
    word_t exp_q[$];
    log_t  out_log[$];
    logic [31:0] cnt = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model and monitor, sampled on the falling edge.
    always @(negedge aclk) begin
        cyc++;
        if (!aresetn) begin
            check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
            check("rst_tlast", 64'(m_axis_tlast), 64'd0);
            check("rst_tdata", 64'(m_axis_tdata), 64'd0);
            check("rst_tready", 64'(s_axis_tready), 64'd0);
            exp_q.delete();
            s_fire = 0;
        end else begin
            check("tvalid", 64'(m_axis_tvalid), 64'(exp_q.size() != 0));
            check("s_tready", 64'(s_axis_tready),
                  64'(exp_q.size() == 0 || (m_axis_tready && exp_q.size() == 1)));
            if (m_axis_tvalid && exp_q.size() != 0) begin
                check("tdata", 64'(m_axis_tdata), 64'(exp_q[0].data));
                check("tlast", 64'(m_axis_tlast), 64'(exp_q[0].last));
            end
            if (m_axis_tvalid && m_axis_tready && exp_q.size() != 0) begin
                out_log.push_back('{data: m_axis_tdata, last: m_axis_tlast, cyc: cyc});
                void'(exp_q.pop_front());
            end
            s_fire = s_axis_tvalid && s_axis_tready;
            if (s_fire) begin
                for (int k = 0; k < RATIO; k++) begin
                    exp_q.push_back('{data: s_axis_tdata[k*MW +: MW],
                                      last: s_axis_tlast && (k == RATIO - 1)});
                end
            end
        end
    end

    task automatic idle_inputs();
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = {$urandom, $urandom};
        s_axis_tlast  = 1'($urandom);
    endtask

    // Offer one beat and wait (bounded) for it to be accepted.
    task automatic send_beat(input logic [SW-1:0] d, input logic l);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        for (int i = 0; i < 50; i++) begin
            @(negedge aclk);
            if (s_axis_tvalid && s_axis_tready) begin
                @(posedge aclk);
                #1;
                idle_inputs();
                return;
            end
        end
        check("send_timeout", 64'd1, 64'd0);
        idle_inputs();
    endtask

    task automatic drain(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic run(input int cycles, input int src_pct, input int dst_pct,
                       input bit cnt_mode, input bit gap4);
        bit want;
        for (int c = 0; c < cycles; c++) begin
            @(posedge aclk);
            #1;
            if (!s_axis_tvalid || s_fire) begin
                want = gap4 ? (c % 4 == 0) : ($urandom_range(99) < src_pct);
                if (want) begin
                    s_axis_tvalid = 1'b1;
                    if (cnt_mode) begin
                        s_axis_tdata = {cnt + 32'd1, cnt};
                        cnt          = cnt + 32'd2;
                    end else begin
                        s_axis_tdata = {$urandom, $urandom};
                    end
                    s_axis_tlast = ($urandom_range(3) == 0);
                end else begin
                    idle_inputs();
                end
            end
            m_axis_tready = ($urandom_range(99) < dst_pct);
        end
        @(posedge aclk);
        #1;
        idle_inputs();
        m_axis_tready = 1'b1;
        drain(10);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        aresetn       = 1'b0;
        m_axis_tready = 1'b0;
        idle_inputs();
        repeat (3) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        @(negedge aclk);
        check("ready_after_rst", 64'(s_axis_tready), 64'd1);
        check("tvalid_after_rst", 64'(m_axis_tvalid), 64'd0);

        // Back-to-back beats, sink always ready.
        m_axis_tready = 1'b1;
        out_log.delete();
        @(posedge aclk);
        #1;
        send_beat(64'h00000001_00000000, 1'b0);
        send_beat(64'h00000003_00000002, 1'b0);
        drain(5);
        check("b2b_words", 64'(out_log.size()), 64'd4);
        if (out_log.size() == 4) begin
            for (int i = 0; i < 4; i++) check("b2b_data", 64'(out_log[i].data), 64'(i));
            check("b2b_span", 64'(out_log[3].cyc - out_log[0].cyc), 64'd3);
        end

        // Backpressure: lower word must be held while the sink stalls.
        m_axis_tready = 1'b0;
        out_log.delete();
        send_beat(64'hDEADBEEF_CAFEF00D, 1'b0);
        repeat (5) begin
            @(negedge aclk);
            check("bp_hold", 64'(m_axis_tdata), 64'hCAFEF00D);
            check("bp_valid", 64'(m_axis_tvalid), 64'd1);
            check("bp_ready", 64'(s_axis_tready), 64'd0);
        end
        @(posedge aclk);
        #1;
        m_axis_tready = 1'b1;
        drain(4);
        check("bp_words", 64'(out_log.size()), 64'd2);
        if (out_log.size() == 2) begin
            check("bp_w0", 64'(out_log[0].data), 64'hCAFEF00D);
            check("bp_w1", 64'(out_log[1].data), 64'hDEADBEEF);
        end

        // Packet boundary: tlast only on word 6.
        out_log.delete();
        send_beat({$urandom, $urandom}, 1'b0);
        send_beat({$urandom, $urandom}, 1'b0);
        send_beat({$urandom, $urandom}, 1'b1);
        drain(5);
        check("pkt_words", 64'(out_log.size()), 64'd6);
        if (out_log.size() == 6) begin
            for (int i = 0; i < 6; i++) check("pkt_last", 64'(out_log[i].last), 64'(i == 5));
        end

        // Reset after the lower word has been taken: upper word must vanish.
        out_log.delete();
        send_beat(64'h11111111_22222222, 1'b0);
        @(negedge aclk);
        check("rst_mid_lower", 64'(m_axis_tdata), 64'h22222222);
        @(posedge aclk);
        #1;
        aresetn = 1'b0;
        #1;
        check("rst_async_clear", 64'(m_axis_tvalid), 64'd0);
        repeat (2) @(negedge aclk);
        #2;
        aresetn = 1'b1;
        repeat (4) begin
            @(negedge aclk);
            check("post_rst_idle", 64'(m_axis_tvalid), 64'd0);
        end
        check("rst_mid_words", 64'(out_log.size()), 64'd1);
        foreach (out_log[i]) check("rst_mid_no_upper", 64'(out_log[i].data == 32'h11111111), 64'd0);
        @(posedge aclk);
        #1;

        // Randomized traffic with random backpressure.
        run(400, 70, 60, 1'b0, 1'b0);
        run(300, 100, 50, 1'b0, 1'b0);

        // Gappy source: one offer in four, sink always ready.
        out_log.delete();
        run(200, 100, 100, 1'b0, 1'b1);
        check("gap_words", 64'(out_log.size()), 64'd100);

        // Counter loopback: 1024 consecutive words without gaps.
        out_log.delete();
        cnt = 0;
        run(1040, 100, 100, 1'b1, 1'b0);
        check("cnt_enough", 64'(out_log.size() >= 1024), 64'd1);
        if (out_log.size() >= 1024) begin
            for (int i = 0; i < 1024; i++) check("cnt_seq", 64'(out_log[i].data), 64'(i));
            check("cnt_span", 64'(out_log[1023].cyc - out_log[0].cyc), 64'd1023);
        end

        check("final_empty", 64'(m_axis_tvalid), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
